// File: rtl/load_pkg.sv
// Shared constants for the load unit: funct3 load modes, fault codes, FSM states
// and helpers that classify a request before any memory access is made.
package load_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    localparam logic [1:0] F_NONE     = 2'b00;
    localparam logic [1:0] F_MISALIGN = 2'b01;
    localparam logic [1:0] F_TIMEOUT  = 2'b10;
    localparam logic [1:0] F_ILLEGAL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } state_t;

    function automatic logic is_illegal(input logic [2:0] mode);
        return !(mode == LB || mode == LH || mode == LW || mode == LBU || mode == LHU);
    endfunction

    // Only meaningful for legal modes; bytes can never be misaligned.
    function automatic logic is_misaligned(input logic [2:0] mode, input logic [1:0] off);
        logic res;
        res = 1'b0;
        if ((mode == LH || mode == LHU) && off[0]) res = 1'b1;
        if (mode == LW && off != 2'b00) res = 1'b1;
        return res;
    endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational lane select and sign/zero extension of a loaded memory word.
module load_extract
    import load_pkg::*;
(
    input  logic [2:0]  mode,
    input  logic [1:0]  off,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[8*off +: 8];
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];
        case (mode)
            LB:      data = {{24{byte_sel[7]}}, byte_sel};
            LBU:     data = {24'h000000, byte_sel};
            LH:      data = {{16{half_sel[15]}}, half_sel};
            LHU:     data = {16'h0000, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// Load unit: classifies a core load, issues a word read with req/ack handshake,
// and returns the extracted, extended result with a fault code on a one-cycle done.
module load_unit
    import load_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned AW      = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_req,
    input  logic [2:0]    ld_mode,
    input  logic [AW-1:0] ld_addr,
    output logic          ld_busy,
    output logic          ld_done,
    output logic [31:0]   ld_data,
    output logic [1:0]    ld_fault,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [31:0]   mem_rdata
);

    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state;
    logic [2:0]    mode_q;
    logic [1:0]    off_q;
    logic [CW-1:0] cnt;
    logic [31:0]   ext_data;

    load_extract u_extract (
        .mode  (mode_q),
        .off   (off_q),
        .rdata (mem_rdata),
        .data  (ext_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mode_q   <= 3'b000;
            off_q    <= 2'b00;
            cnt      <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            ld_busy  <= 1'b0;
            ld_done  <= 1'b0;
            ld_data  <= 32'h0;
            ld_fault <= F_NONE;
        end else begin
            ld_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (ld_req) begin
                        mode_q   <= ld_mode;
                        off_q    <= ld_addr[1:0];
                        mem_addr <= {ld_addr[AW-1:2], 2'b00};
                        cnt      <= '0;
                        if (is_illegal(ld_mode)) begin
                            ld_fault <= F_ILLEGAL;
                            ld_done  <= 1'b1;
                            state    <= DONE;
                        end else if (is_misaligned(ld_mode, ld_addr[1:0])) begin
                            ld_fault <= F_MISALIGN;
                            ld_done  <= 1'b1;
                            state    <= DONE;
                        end else begin
                            mem_req <= 1'b1;
                            ld_busy <= 1'b1;
                            state   <= REQ;
                        end
                    end
                end
                REQ: begin
                    // An ack in the final counted cycle still completes normally.
                    if (mem_ack) begin
                        ld_data  <= ext_data;
                        ld_fault <= F_NONE;
                        mem_req  <= 1'b0;
                        ld_busy  <= 1'b0;
                        ld_done  <= 1'b1;
                        cnt      <= '0;
                        state    <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        ld_fault <= F_TIMEOUT;
                        mem_req  <= 1'b0;
                        ld_busy  <= 1'b0;
                        ld_done  <= 1'b1;
                        cnt      <= '0;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit; completed loads are checked against a queue of
// expected results filled when each request is driven.
module tb_load_unit;

    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned AW      = 32;

    logic          clk;
    logic          rst;
    logic          ld_req;
    logic [2:0]    ld_mode;
    logic [AW-1:0] ld_addr;
    logic          ld_busy;
    logic          ld_done;
    logic [31:0]   ld_data;
    logic [1:0]    ld_fault;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [31:0]   mem_rdata;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  fault;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors   = 0;
    int   checks   = 0;
    int   done_cnt = 0;
    int   pushed   = 0;

    load_unit #(
        .TIMEOUT (TIMEOUT),
        .AW      (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ld_req    (ld_req),
        .ld_mode   (ld_mode),
        .ld_addr   (ld_addr),
        .ld_busy   (ld_busy),
        .ld_done   (ld_done),
        .ld_data   (ld_data),
        .ld_fault  (ld_fault),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] data, input logic [1:0] fault);
        exp_t e;
        e.data  = data;
        e.fault = fault;
        sb.push_back(e);
        pushed++;
    endtask

    task automatic check_reset(input string pfx);
        chk({pfx, "_mem_req"}, mem_req, 0);
        chk({pfx, "_mem_addr"}, mem_addr, 0);
        chk({pfx, "_busy"}, ld_busy, 0);
        chk({pfx, "_done"}, ld_done, 0);
        chk({pfx, "_data"}, ld_data, 0);
        chk({pfx, "_fault"}, ld_fault, 0);
    endtask

    // Drive one request so it is sampled at the next edge; returns in cycle 1.
    task automatic issue(input logic [2:0] mode, input logic [AW-1:0] addr);
        ld_req  = 1'b1;
        ld_mode = mode;
        ld_addr = addr;
        tick();
        ld_req  = 1'b0;
    endtask

    always @(negedge clk) begin
        if (ld_done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_done", ld_done, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_data", ld_data, mon_e.data);
                chk("sb_fault", ld_fault, mon_e.fault);
            end
        end
    end

    initial begin
        int n;
        rst       = 1'b1;
        ld_req    = 1'b0;
        ld_mode   = 3'b000;
        ld_addr   = '0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        tick();
        tick();
        check_reset("rst0");
        rst = 1'b0;
        tick();

        // LB at 0x1003, ack in the first REQ cycle.
        push(32'hFFFF_FF80, 2'b00);
        issue(3'b000, 32'h0000_1003);
        chk("lb_mem_req", mem_req, 1);
        chk("lb_mem_addr", mem_addr, 32'h0000_1000);
        chk("lb_busy", ld_busy, 1);
        chk("lb_no_done_c1", ld_done, 0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h80FF_1234;
        tick();
        mem_ack = 1'b0;
        chk("lb_done_c2", ld_done, 1);
        chk("lb_mem_req_drop", mem_req, 0);
        tick();
        chk("lb_done_pulse", ld_done, 0);

        // LHU at 0x2002, ack arrives in the fourth REQ cycle.
        push(32'h0000_BEEF, 2'b00);
        issue(3'b101, 32'h0000_2002);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (ld_busy) n++;
            if (i == 3) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'hBEEF_0001;
            end
            tick();
        end
        mem_ack = 1'b0;
        chk("lhu_busy_cycles", n, 4);
        chk("lhu_done", ld_done, 1);
        chk("lhu_busy_low", ld_busy, 0);
        tick();

        // Misaligned LW and LH, then an illegal mode: no memory request.
        push(32'h0000_BEEF, 2'b01);
        issue(3'b010, 32'h0000_3001);
        chk("lw_mis_no_req", mem_req, 0);
        chk("lw_mis_done_c1", ld_done, 1);
        tick();
        push(32'h0000_BEEF, 2'b01);
        issue(3'b001, 32'h0000_3003);
        chk("lh_mis_no_req", mem_req, 0);
        chk("lh_mis_done_c1", ld_done, 1);
        tick();
        push(32'h0000_BEEF, 2'b11);
        issue(3'b011, 32'h0000_3000);
        chk("ill_no_req", mem_req, 0);
        chk("ill_done_c1", ld_done, 1);
        tick();

        // LW never acknowledged: bus timeout.
        push(32'h0000_BEEF, 2'b10);
        issue(3'b010, 32'h0000_4000);
        n = 0;
        for (int i = 0; i < 40 && !ld_done; i++) begin
            if (mem_req) n++;
            tick();
        end
        chk("to_done_seen", ld_done, 1);
        chk("to_req_cycles", n, TIMEOUT);
        tick();

        // Ack in the last counted cycle wins over the timeout.
        push(32'hCAFE_F00D, 2'b00);
        issue(3'b010, 32'h0000_5000);
        for (int i = 0; i < TIMEOUT; i++) begin
            if (i == TIMEOUT - 1) begin
                chk("edge_req_still_high", mem_req, 1);
                mem_ack   = 1'b1;
                mem_rdata = 32'hCAFE_F00D;
            end
            tick();
        end
        mem_ack = 1'b0;
        chk("edge_done", ld_done, 1);
        tick();

        // Reset during the second REQ cycle, then a late ack.
        issue(3'b010, 32'h0000_6000);
        tick();
        chk("rst_req_before", mem_req, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset("rst_mid");
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        tick();
        mem_ack = 1'b0;
        chk("late_ack_no_done", ld_done, 0);
        chk("late_ack_no_req", mem_req, 0);
        tick();
        chk("late_ack_data", ld_data, 0);

        // Back-to-back with ld_req held high.
        ld_req  = 1'b1;
        ld_mode = 3'b100;
        ld_addr = 32'h0000_7001;
        tick();
        push(32'h0000_00AB, 2'b00);
        chk("b2b_req1", mem_req, 1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0000_AB00;
        tick();
        mem_ack = 1'b0;
        chk("b2b_done1", ld_done, 1);
        tick();
        chk("b2b_idle_no_req", mem_req, 0);
        chk("b2b_idle_no_done", ld_done, 0);
        tick();
        push(32'h0000_00CD, 2'b00);
        chk("b2b_req2", mem_req, 1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0000_CD00;
        tick();
        mem_ack = 1'b0;
        ld_req  = 1'b0;
        chk("b2b_done2", ld_done, 1);
        tick();
        tick();
        tick();

        chk("done_count", done_cnt, pushed);
        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
